// File: rtl/rsa_modexp_engine_pkg.sv
// Shared types for the RSA modular-exponentiation engine.
// FSM state encoding and default operand width.
package rsa_modexp_engine_pkg;

    localparam int DEF_BITS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SQR,
        S_MUL,
        S_FIN
    } state_t;

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// Request/response bundle of the modexp engine.
// master drives operands and control, slave returns status and result.
interface rsa_modexp_engine_if #(
    parameter int BITS     = 32,
    parameter int EXP_BITS = BITS
);
    logic                start;
    logic                abort;
    logic [BITS-1:0]     m;
    logic [EXP_BITS-1:0] e;
    logic [BITS-1:0]     n;
    logic                busy;
    logic                done;
    logic                err;
    logic [BITS-1:0]     r;

    modport master (
        output start, abort, m, e, n,
        input  busy, done, err, r
    );

    modport slave (
        input  start, abort, m, e, n,
        output busy, done, err, r
    );
endinterface

// File: rtl/rsa_modexp_engine_mod_mult.sv
// Bit-serial interleaved (Blakley) modular multiplier, p = a*b mod n.
// The go cycle performs the first step; rdy flags the cycle finishing the last one.
module rsa_mod_mult #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            go,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] p,
    output logic [BITS-1:0] p_nxt,
    output logic            rdy
);
    localparam int CW = $clog2(BITS);

    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic [CW-1:0]   cnt;
    logic            run;

    // One Blakley step: double, reduce, conditionally add b, reduce.
    function automatic logic [BITS-1:0] step(
        input logic [BITS-1:0] pv,
        input logic [BITS-1:0] bv,
        input logic [BITS-1:0] nv,
        input logic            abit
    );
        logic [BITS:0] t;
        t = {pv, 1'b0};
        if (t >= {1'b0, nv})
            t = t - {1'b0, nv};
        if (abit) begin
            t = t + {1'b0, bv};
            if (t >= {1'b0, nv})
                t = t - {1'b0, nv};
        end
        return t[BITS-1:0];
    endfunction

    // Next partial product; a fresh go starts from p=0 with live operands.
    always_comb begin
        p_nxt = '0;
        if (go)
            p_nxt = step('0, b, n, a[BITS-1]);
        else
            p_nxt = step(p, b_q, n, a_q[BITS-1]);
    end

    assign rdy = run && (cnt == CW'(1));

    // Step sequencer: go loads operands, then BITS-1 further steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p   <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (go) begin
            p   <= p_nxt;
            a_q <= a << 1;
            b_q <= b;
            cnt <= CW'(BITS - 1);
            run <= 1'b1;
        end else if (run) begin
            p   <= p_nxt;
            a_q <= a_q << 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                run <= 1'b0;
        end
    end
endmodule

// File: rtl/rsa_modexp_engine.sv
// RSA modexp r = m^e mod n, left-to-right square-and-multiply.
// Sequences rsa_mod_mult; the accumulator is the multiplier's product register.
module rsa_modexp_engine
    import rsa_modexp_engine_pkg::*;
#(
    parameter int BITS     = DEF_BITS,
    parameter int EXP_BITS = BITS
) (
    input  logic               clk,
    input  logic               reset_n,
    rsa_modexp_engine_if.slave bus
);
    localparam int JW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

    state_t              state;
    logic [BITS-1:0]     m_q;
    logic [BITS-1:0]     n_q;
    logic [EXP_BITS-1:0] e_q;
    logic [JW-1:0]       j;
    logic                one_q;
    logic                go_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [BITS-1:0]     r_q;

    logic [BITS-1:0]     p;
    logic [BITS-1:0]     p_nxt;
    logic [BITS-1:0]     acc;
    logic [BITS-1:0]     mm_b;
    logic                rdy;

    assign acc  = one_q ? BITS'(1) : p;
    assign mm_b = (state == S_MUL) ? m_q : acc;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.r    = r_q;

    rsa_mod_mult #(.BITS(BITS)) u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go_q),
        .a       (acc),
        .b       (mm_b),
        .n       (n_q),
        .p       (p),
        .p_nxt   (p_nxt),
        .rdy     (rdy)
    );

    // Control FSM: accept, operand check, square/multiply per exponent bit, finish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            m_q    <= '0;
            n_q    <= '0;
            e_q    <= '0;
            j      <= '0;
            one_q  <= 1'b0;
            go_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            r_q    <= '0;
        end else begin
            go_q <= 1'b0;
            if (go_q)
                one_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        m_q    <= bus.m;
                        e_q    <= bus.e;
                        n_q    <= bus.n;
                        j      <= JW'(EXP_BITS - 1);
                        one_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (n_q < BITS'(2) || m_q >= n_q) begin
                        err_q  <= 1'b1;
                        r_q    <= '0;
                        done_q <= 1'b1;
                        state  <= S_FIN;
                    end else begin
                        go_q  <= 1'b1;
                        state <= S_SQR;
                    end
                end
                S_SQR, S_MUL: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (rdy) begin
                        if (state == S_SQR && e_q[j]) begin
                            go_q  <= 1'b1;
                            state <= S_MUL;
                        end else if (j == '0) begin
                            err_q  <= 1'b0;
                            r_q    <= p_nxt;
                            done_q <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            j     <= j - JW'(1);
                            go_q  <= 1'b1;
                            state <= S_SQR;
                        end
                    end
                end
                S_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Testbench for rsa_modexp_engine: 32-bit and 16-bit instances
// checked against a right-to-left modexp reference model.
module tb_rsa_modexp_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic use32 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rsa_modexp_engine_if #(.BITS(32), .EXP_BITS(32)) b32 ();
    rsa_modexp_engine_if #(.BITS(16), .EXP_BITS(16)) b16 ();

    rsa_modexp_engine #(.BITS(32), .EXP_BITS(32)) dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b32)
    );

    rsa_modexp_engine #(.BITS(16), .EXP_BITS(16)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b16)
    );

    logic        s_busy;
    logic        s_done;
    logic        s_err;
    logic [31:0] s_r;

    always_comb begin
        s_busy = use32 ? b32.busy : b16.busy;
        s_done = use32 ? b32.done : b16.done;
        s_err  = use32 ? b32.err  : b16.err;
        s_r    = use32 ? b32.r    : {16'h0, b16.r};
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_exp(input logic [63:0] m,
                                            input logic [63:0] e,
                                            input logic [63:0] n);
        logic [63:0] acc;
        logic [63:0] base;
        acc  = 64'd1 % n;
        base = m % n;
        while (e != 0) begin
            if (e[0])
                acc = (acc * base) % n;
            base = (base * base) % n;
            e = e >> 1;
        end
        return acc;
    endfunction

    task automatic drive(input logic st, input logic ab,
                         input logic [31:0] m, input logic [31:0] e,
                         input logic [31:0] n);
        b32.start = use32 & st;
        b32.abort = use32 & ab;
        b32.m = m;
        b32.e = e;
        b32.n = n;
        b16.start = !use32 & st;
        b16.abort = !use32 & ab;
        b16.m = m[15:0];
        b16.e = e[15:0];
        b16.n = n[15:0];
    endtask

    task automatic expect_of(input logic [31:0] m, input logic [31:0] e,
                             input logic [31:0] n, output logic [31:0] xr,
                             output logic xe, output int xl);
        int w;
        w = use32 ? 32 : 16;
        if (!use32) begin
            m = m & 32'hFFFF;
            e = e & 32'hFFFF;
            n = n & 32'hFFFF;
        end
        xe = (n < 2) || (m >= n);
        xr = xe ? 32'd0 : 32'(ref_exp({32'h0, m}, {32'h0, e}, {32'h0, n}));
        xl = xe ? 1 : 1 + w * (w + $countones(e));
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] e,
                            input logic [31:0] n);
        @(negedge clk);
        drive(1'b1, 1'b0, m, e, n);
        @(negedge clk);
        drive(1'b0, 1'b0, $urandom, $urandom, $urandom);
    endtask

    task automatic wait_done(input string tag, input int start_cyc,
                             output int cyc);
        cyc = start_cyc;
        while (!s_done && cyc < start_cyc + 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!s_done)
            check({tag, "_timeout"}, 64'(cyc), 64'(start_cyc + 3000 + 1));
    endtask

    task automatic check_done(input string tag, input int cyc, input int xl,
                              input logic [31:0] xr, input logic xe);
        check({tag, "_lat"}, 64'(cyc), 64'(xl));
        check({tag, "_r"}, {32'h0, s_r}, {32'h0, xr});
        check({tag, "_err"}, {63'h0, s_err}, {63'h0, xe});
        @(negedge clk);
        check({tag, "_idle"}, {62'h0, s_busy, s_done}, 64'h0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] m,
                          input logic [31:0] e, input logic [31:0] n);
        logic [31:0] xr;
        logic        xe;
        int          xl;
        int          cyc;
        expect_of(m, e, n, xr, xe, xl);
        start_op(m, e, n);
        check({tag, "_busy"}, {63'h0, s_busy}, 64'h1);
        wait_done(tag, 0, cyc);
        check_done(tag, cyc, xl, xr, xe);
    endtask

    initial begin
        logic [31:0] xr;
        logic        xe;
        int          xl;
        int          cyc;
        int          dcount;
        logic [31:0] prev_r;
        logic        prev_err;
        logic [31:0] rm;
        logic [31:0] re;
        logic [31:0] rn;

        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        use32 = 1'b1;
        check("rst32", {29'h0, s_busy, s_done, s_err, s_r}, 64'h0);
        use32 = 1'b0;
        check("rst16", {29'h0, s_busy, s_done, s_err, s_r}, 64'h0);
        reset_n = 1'b1;

        use32 = 1'b0;
        run_op("t1", 32'd4, 32'd13, 32'd497);

        use32 = 1'b1;
        run_op("t2a", 32'd65, 32'd17, 32'd3233);
        run_op("t2b", 32'd2790, 32'd2753, 32'd3233);
        run_op("t3_e0", 32'd5, 32'd0, 32'd7);
        run_op("t3_m0", 32'd0, 32'd3, 32'd7);
        run_op("t3_n1", 32'd3, 32'd5, 32'd1);
        run_op("t3_mge", 32'd9, 32'd5, 32'd7);
        run_op("t3_big", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        expect_of(32'd65, 32'd17, 32'd3233, xr, xe, xl);
        start_op(32'd65, 32'd17, 32'd3233);
        repeat (20) @(negedge clk);
        drive(1'b1, 1'b0, 32'd2, 32'd5, 32'd11);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd2, 32'd5, 32'd11);
        wait_done("t4", 21, cyc);
        check_done("t4", cyc, xl, xr, xe);

        prev_r   = s_r;
        prev_err = s_err;
        start_op(32'd123, 32'd77, 32'd3001);
        repeat (49) @(negedge clk);
        drive(1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        check("t5_busy", {63'h0, s_busy}, 64'h0);
        check("t5_r", {32'h0, s_r}, {32'h0, prev_r});
        check("t5_err", {63'h0, s_err}, {63'h0, prev_err});
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (s_done)
                dcount++;
        end
        check("t5_nodone", 64'(dcount), 64'h0);
        run_op("t5_new", 32'd123, 32'd77, 32'd3001);

        expect_of(32'd7, 32'd9, 32'd1000, xr, xe, xl);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'd7, 32'd9, 32'd1000);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        check("t5_sa_busy", {63'h0, s_busy}, 64'h1);
        wait_done("t5_sa", 0, cyc);
        check_done("t5_sa", cyc, xl, xr, xe);

        start_op(32'd11, 32'd99, 32'd4093);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst", {29'h0, s_busy, s_done, s_err, s_r}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("t6_after", 32'd11, 32'd99, 32'd4093);

        use32 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rn = 32'($urandom_range(2, 65535));
            rm = 32'($urandom % rn);
            re = 32'($urandom & 32'hFFFF);
            if (i % 10 == 0)
                rm = rn;
            run_op("rnd16", rm, re, rn);
        end

        use32 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rn = $urandom | 32'h2;
            rm = $urandom % rn;
            re = $urandom;
            run_op("rnd32", rm, re, rn);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
